uart_fifo_bridge: RTL
=====================

// Module: uart_fifo_bridge
// PURPOSE
//   Buffering stage between the buart byte UART and the j1a CPU I/O bus. Drains received
//   bytes from buart (valid/rd handshake) into an RX FIFO. Feeds CPU-written bytes from a
//   TX FIFO into buart (wr/busy handshake). Lets the CPU absorb bursts at 460800 baud
//   without polling every byte.
// PARAMETERS
//   RX_DEPTH   16  RX FIFO entries; power of two, >= 2
//   TX_DEPTH   16  TX FIFO entries; power of two, >= 2
// PORTS
//   clk           in   1   system clock; single clock domain
//   reset         in   1   synchronous, active-high reset
//   uart_valid    in   1   buart valid: byte waiting in rx_data
//   uart_rx_data  in   8   buart rx_data
//   uart_rd       out  1   read strobe to buart, one-cycle pulse
//   uart_busy     in   1   buart busy
//   uart_wr       out  1   write strobe to buart, one-cycle pulse
//   uart_tx_data  out  8   byte to buart tx_data; valid while uart_wr=1
//   cpu_rd        in   1   pop RX FIFO head
//   rx_data       out  8   RX FIFO head (first-word fall-through)
//   rx_avail      out  1   RX FIFO non-empty
//   rx_count      out  $clog2(RX_DEPTH)+1  RX occupancy
//   rx_overrun    out  1   sticky: byte dropped because RX FIFO full
//   clr_overrun   in   1   clears rx_overrun
//   cpu_wr        in   1   push tx_data into TX FIFO
//   tx_data       in   8   byte from CPU
//   tx_full       out  1   TX FIFO full
//   tx_count      out  $clog2(TX_DEPTH)+1  TX occupancy
// BEHAVIOUR
//   Reset: both FIFOs empty; uart_rd=0, uart_wr=0, rx_overrun=0, rx_avail=0, tx_full=0,
//     counts=0, uart_tx_data=0.
//   - buart state is untouched; an in-flight TX frame completes.
//   - A byte already held by buart is captured normally after reset.
//   RX capture: in cycle N, uart_valid=1 and uart_rd=0 -> uart_rd=1 in N+1 (registered).
//   - If the RX FIFO accepts in N, uart_rx_data is pushed in N. It is visible on rx_data in N+1.
//   - uart_valid is still high in N+1. It is ignored because uart_rd=1, so no double push.
//   - buart drops valid in N+2.
//   RX full: the byte is still acked (uart_rd pulse) so the buart receiver re-arms.
//   - The byte is discarded and rx_overrun is set in N+1.
//   - rx_overrun stays set until clr_overrun. A set and a clr in the same cycle leave it set.
//   Full with cpu_rd in the same cycle: the push is accepted (count unchanged, no overrun).
//   cpu_rd: rd when empty is ignored. Push+pop when empty: push only; the pop is ignored.
//   TX issue: uart_wr_next = tx_nonempty & ~uart_busy & ~uart_wr.
//   - uart_tx_data is registered from the FIFO head together with uart_wr. The head is popped
//     in the issuing cycle.
//   - Gating on ~uart_wr covers the cycle before buart raises busy. Strobes are >= 2 cycles apart.
//   cpu_wr when full: ignored, byte lost, no flag (CPU must poll tx_full).
//   - Full+cpu_wr+issue-pop in the same cycle: the push is accepted.
//   Latency:
//   - uart_valid to rx_avail: 1 cycle.
//   - cpu_wr to uart_wr (idle UART, empty FIFO): 2 cycles, i.e. FIFO write, then registered strobe.
//   Counts: pointers are $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
//   - count = wptr - rptr.
//   - full when count == DEPTH. Never exceeds DEPTH.
// STRUCTURE
//   - Shared include uart_defs.vh: UART_DATA_W=8 and the default FIFO depths. This bridge and
//     the j1a I/O decode both use it.
//   - One sub-module, sync_fifo #(WIDTH, DEPTH): FWFT, registered pointers, count/full/empty,
//     simultaneous push/pop rules as above. Instanced twice (rx_fifo, tx_fifo).
//   - Bridge top level: RX capture FSM, TX issue FSM, overrun flag.
// TESTING
//   1. Bench: buart behavioural model (valid held until rd; busy high from the cycle after wr,
//      for 40 cycles).
//   2. RX single: valid with 0x5A -> exactly one uart_rd pulse; rx_avail=1 and rx_data=0x5A
//      the next cycle; rx_count=1; cpu_rd -> rx_avail=0.
//   3. RX overrun: 17 bytes 0x00..0x10 with no cpu_rd -> rx_count=16 and rx_overrun=1.
//      Reads return 0x00..0x0F; 0x10 lost. clr_overrun clears the flag.
//   4. TX burst: cpu_wr 0x41,0x42,0x43 back-to-back -> three uart_wr pulses carrying 0x41,0x42,0x43
//      in order. Each pulse occurs only with busy low and >= 2 cycles apart. tx_count returns to 0.
//   5. Boundaries: TX full + cpu_wr + issue pop in the same cycle -> tx_count stays 16.
//      RX empty push+pop -> rx_count=1.
//   6. Reset mid-operation: reset with 5 bytes in each FIFO and uart_busy=1 -> next cycle counts=0,
//      strobes=0, overrun=0. No uart_wr until busy falls and a new cpu_wr arrives.

Source files
------------

// File: rtl/uart_fifo_bridge_pkg.sv
// uart_fifo_bridge_pkg: shared UART byte width and default FIFO depths for the bridge and I/O decode
package uart_fifo_bridge_pkg;
    localparam int UART_DATA_W = 8;
    localparam int RX_DEPTH_DEF = 16;
    localparam int TX_DEPTH_DEF = 16;
    typedef logic [UART_DATA_W-1:0] uart_byte_t;
endpackage

// File: rtl/uart_fifo_bridge_sync_fifo.sv
// sync_fifo: first-word fall-through FIFO with wrap-bit pointers and same-cycle push/pop rules
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wptr, rptr;
    logic do_push, do_pop;
    assign count = wptr - rptr;
    assign full = count == FULL_CNT;
    assign empty = count == '0;
    assign do_pop = pop & ~empty;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign do_push = push & (~full | do_pop);
    assign dout = mem[rptr[AW-1:0]];
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge: buffers buart RX/TX bytes in FIFOs for the j1a CPU I/O bus
module uart_fifo_bridge import uart_fifo_bridge_pkg::*; #(
    parameter int RX_DEPTH = RX_DEPTH_DEF,
    parameter int TX_DEPTH = TX_DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        uart_valid,
    input  logic [UART_DATA_W-1:0]      uart_rx_data,
    output logic                        uart_rd,
    input  logic                        uart_busy,
    output logic                        uart_wr,
    output logic [UART_DATA_W-1:0]      uart_tx_data,
    input  logic                        cpu_rd,
    output logic [UART_DATA_W-1:0]      rx_data,
    output logic                        rx_avail,
    output logic [$clog2(RX_DEPTH):0]   rx_count,
    output logic                        rx_overrun,
    input  logic                        clr_overrun,
    input  logic                        cpu_wr,
    input  logic [UART_DATA_W-1:0]      tx_data,
    output logic                        tx_full,
    output logic [$clog2(TX_DEPTH):0]   tx_count
);
    logic rx_push, rx_full, rx_empty, tx_empty, issue;
    uart_byte_t tx_head;
    // valid stays high the cycle after the ack, so the pending strobe masks a second capture
    assign rx_push = uart_valid & ~uart_rd;
    assign rx_avail = ~rx_empty;
    // busy rises one cycle after wr, so the outstanding strobe blocks back-to-back issue
    assign issue = ~tx_empty & ~uart_busy & ~uart_wr;
    always_ff @(posedge clk) begin
        if (reset) begin
            uart_rd <= 1'b0;
            uart_wr <= 1'b0;
            uart_tx_data <= '0;
            rx_overrun <= 1'b0;
        end else begin
            uart_rd <= rx_push;
            uart_wr <= issue;
            if (issue) uart_tx_data <= tx_head;
            rx_overrun <= (rx_push & rx_full & ~cpu_rd) | (rx_overrun & ~clr_overrun);
        end
    end
    sync_fifo #(.WIDTH(UART_DATA_W), .DEPTH(RX_DEPTH)) rx_fifo (
        .clk(clk), .rst(reset), .push(rx_push), .din(uart_rx_data), .pop(cpu_rd),
        .dout(rx_data), .count(rx_count), .full(rx_full), .empty(rx_empty)
    );
    sync_fifo #(.WIDTH(UART_DATA_W), .DEPTH(TX_DEPTH)) tx_fifo (
        .clk(clk), .rst(reset), .push(cpu_wr), .din(tx_data), .pop(issue),
        .dout(tx_head), .count(tx_count), .full(tx_full), .empty(tx_empty)
    );
endmodule
